bias_relu: RTL and testbench
============================

Name: bias_relu

Overview:
- Element-wise post-convolution stage, directly upstream of the max-pool block.
- Streams M feature maps of R x C accumulator values from the conv accumulator buffer and adds a per-map bias. Applies ReLU and writes results to the out buffer, which the max-pool stage then reads through its out_ra/out_rd port.
- Started by the layer controller via en; signals completion via done.

Parameters:
- DATA_SIZE, 16, data word width; signed two's complement.
- MEM_SIZE, 16, buffer address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset).
- en  input  1  level start/run enable from the layer controller.
- R  input  DATA_SIZE  rows per feature map (unsigned).
- C  input  DATA_SIZE  columns per feature map (unsigned).
- M  input  DATA_SIZE  number of feature maps (unsigned).
- acc_ra  output  MEM_SIZE  accumulator buffer read address.
- acc_rd  input  DATA_SIZE  accumulator read data; 1-cycle synchronous read latency.
- bias_ra  output  MEM_SIZE  bias table read address.
- bias_rd  input  DATA_SIZE  bias read data; 1-cycle latency.
- out_we  output  1  out buffer write enable.
- out_wa  output  MEM_SIZE  out buffer write address.
- out_wd  output  DATA_SIZE  out buffer write data.
- done  output  1  layer complete.

Behaviour:
- Reset (rst=0 at a clk edge): next cycle all outputs are 0, FSM is IDLE, counters are 0, pipeline valids are 0. Reset has priority over every other event, including mid-run.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when en=1. R, C and M are sampled in this cycle; later changes are ignored until the next IDLE.
- IDLE -> DONE directly when en=1 and any of R, C, M is 0. No writes occur.
- Counters in RUN:
  - pix runs 0..R*C-1; mm runs 0..M-1; lin is the linear address, 0..M*R*C-1.
  - All increment once per cycle: pix wraps to 0 and mm increments at pix=R*C-1.
  - Arithmetic is modulo 2^MEM_SIZE with no overflow check; the controller guarantees M*R*C <= 2^MEM_SIZE.
- Read addresses: acc_ra = lin and bias_ra = mm, both registered outputs driven in RUN.
- Pipeline, 3 cycles from acc_ra to out_we:
  - Cycle t: addresses issued.
  - Cycle t+1: acc_rd and bias_rd valid; sum = acc_rd + bias_rd, computed at DATA_SIZE+1 bits, then saturated (see Optional Feature) and registered.
  - Cycle t+2: ReLU applied (negative -> 0) and the out_* registers loaded.
  - Cycle t+3: out_we=1 with out_wa = lin of cycle t and out_wd = result.
- Throughput: one element per cycle, no bubbles, including across map boundaries.
- RUN -> DRAIN after issuing lin = M*R*C-1. DRAIN lasts until the last write completes (3 cycles), then DONE.
- DONE: done=1, out_we=0. done stays high while en=1. en=0 -> IDLE, and done drops the next cycle.
- en deasserted during RUN or DRAIN aborts:
  - Next state is IDLE and pipeline valids are cleared, so no further out_we pulses.
  - done is not asserted; counters are zeroed.
- out_we is never asserted outside RUN/DRAIN.
- acc_ra and bias_ra hold their last value when not in RUN.

Optional Feature:
- Macro: BIAS_RELU_SAT_EN.
- Defined: the DATA_SIZE+1-bit sum saturates to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] before ReLU, so positive overflow yields 0x7FFF for DATA_SIZE=16.
- Undefined: the sum wraps to DATA_SIZE bits (the low DATA_SIZE bits are kept), then ReLU is applied to the wrapped value.

Test Plan:
- Basic stream: R=2, C=2, M=2, acc = {5,-3,0,7, -1,2,-8,4}, bias = {1,-2} -> writes at addrs 0..7 = {6,0,1,8, 0,0,0,2}. First out_we occurs 3 cycles after the first acc_ra; then 8 consecutive out_we cycles; done rises 1 cycle after the last write.
- Saturation: acc=0x7FF0, bias=0x0020, R=C=M=1.
  - With BIAS_RELU_SAT_EN: out_wd=0x7FFF.
  - Without it: out_wd=0 (wraps to 0x8010, which is negative, so ReLU gives 0).
- Zero dimension: M=0 with en=1 -> no out_we; done=1 two cycles after en rises; en=0 -> done=0 the next cycle.
- Abort: R=4, C=4, M=1; en dropped after 5 RUN cycles -> no out_we from the cycle after the drop plus at most the writes already in flight (<=2); done stays 0; a later restart with en=1 processes all 16 elements from addr 0.
- Reset mid-run: rst=0 for one cycle during DRAIN -> next cycle out_we=0, done=0, acc_ra=0, FSM is IDLE; with en held 1 the block restarts from addr 0.
- Back-to-back layers: after DONE, drop en for 1 cycle, then start with R=1, C=3, M=2 -> 6 writes at addrs 0..5 with bias index 0,0,0,1,1,1.

Source files
------------

// File: rtl/bias_relu.sv
// bias_relu: post-convolution bias-add + ReLU stage feeding the max-pool block.
//
// Streams M feature maps of R x C accumulator words. Each word gets the bias of
// its map added, is clamped at zero, and is written to the out buffer at the
// word's linear address. The throughput is one element per clock.
//
// Optional build macro: BIAS_RELU_SAT_EN
//   defined   - the DATA_SIZE+1-bit sum saturates to the signed DATA_SIZE range
//   undefined - the sum wraps to DATA_SIZE bits
//
// Ports:
//   clk      clock
//   rst      synchronous active-low reset
//   en       level start/run enable (dropping it mid-layer aborts)
//   R, C, M  rows, columns, map count (sampled when leaving IDLE)
//   acc_ra   accumulator read address, acc_rd data (1-cycle latency)
//   bias_ra  bias read address, bias_rd data (1-cycle latency)
//   out_we   out buffer write enable, out_wa address, out_wd data
//   done     layer complete, held while en stays high
module bias_relu #(
  parameter int DATA_SIZE = 16,
  parameter int MEM_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] R,
  input  logic [DATA_SIZE-1:0] C,
  input  logic [DATA_SIZE-1:0] M,
  output logic [MEM_SIZE-1:0]  acc_ra,
  input  logic [DATA_SIZE-1:0] acc_rd,
  output logic [MEM_SIZE-1:0]  bias_ra,
  input  logic [DATA_SIZE-1:0] bias_rd,
  output logic                 out_we,
  output logic [MEM_SIZE-1:0]  out_wa,
  output logic [DATA_SIZE-1:0] out_wd,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [MEM_SIZE-1:0]  r_pix, r_mm, r_lin;
  logic [MEM_SIZE-1:0]  r_pix_last, r_lin_last;
  logic [MEM_SIZE-1:0]  r_acc_ra, r_bias_ra;
  logic [MEM_SIZE-1:0]  r_a1, r_a2, r_out_wa;
  logic                 r_v0, r_v1, r_v2;
  logic                 r_out_we, r_done;
  logic [DATA_SIZE-1:0] r_sum, r_out_wd;

  logic [MEM_SIZE-1:0]  w_rc, w_mrc;
  logic [DATA_SIZE-1:0] w_sat, w_relu;
  logic                 w_zero_dim;

  // Address arithmetic is modulo 2^MEM_SIZE, so low bits of the operands suffice.
  assign w_rc       = MEM_SIZE'(R) * MEM_SIZE'(C);
  assign w_mrc      = w_rc * MEM_SIZE'(M);
  assign w_zero_dim = (R == '0) || (C == '0) || (M == '0);

`ifdef BIAS_RELU_SAT_EN
  logic [DATA_SIZE:0] w_sum;
  always_comb begin
    w_sum = {acc_rd[DATA_SIZE-1], acc_rd} + {bias_rd[DATA_SIZE-1], bias_rd};
    w_sat = w_sum[DATA_SIZE-1:0];
    // Top two bits disagree only on overflow; the extra bit carries the true sign.
    if (w_sum[DATA_SIZE] != w_sum[DATA_SIZE-1])
      w_sat = w_sum[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                               : {1'b0, {(DATA_SIZE-1){1'b1}}};
  end
`else
  assign w_sat = acc_rd + bias_rd;
`endif

  assign w_relu = r_sum[DATA_SIZE-1] ? '0 : r_sum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pix      <= '0;
      r_mm       <= '0;
      r_lin      <= '0;
      r_pix_last <= '0;
      r_lin_last <= '0;
      r_acc_ra   <= '0;
      r_bias_ra  <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_out_wa   <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_out_we   <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_out_wd   <= '0;
    end else begin
      // Datapath: stage 0 = address issued, 1 = read data summed, 2 = ReLU, out regs.
      r_v0     <= 1'b0;
      r_v1     <= r_v0;
      r_a1     <= r_acc_ra;
      r_v2     <= r_v1;
      r_a2     <= r_a1;
      r_sum    <= w_sat;
      r_out_we <= r_v2;
      r_out_wa <= r_a2;
      r_out_wd <= w_relu;

      if (((r_state == S_RUN) || (r_state == S_DRAIN)) && !en) begin
        // Abort: flush everything in flight so no further writes escape.
        r_state  <= S_IDLE;
        r_v1     <= 1'b0;
        r_v2     <= 1'b0;
        r_out_we <= 1'b0;
        r_pix    <= '0;
        r_mm     <= '0;
        r_lin    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_done <= 1'b0;
            if (en) begin
              if (w_zero_dim) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state    <= S_RUN;
                r_pix_last <= w_rc - 1'b1;
                r_lin_last <= w_mrc - 1'b1;
                r_pix      <= '0;
                r_mm       <= '0;
                r_lin      <= '0;
              end
            end
          end
          S_RUN: begin
            r_acc_ra  <= r_lin;
            r_bias_ra <= r_mm;
            r_v0      <= 1'b1;
            if (r_lin == r_lin_last) begin
              r_state <= S_DRAIN;
              r_pix   <= '0;
              r_mm    <= '0;
              r_lin   <= '0;
            end else begin
              r_lin <= r_lin + 1'b1;
              if (r_pix == r_pix_last) begin
                r_pix <= '0;
                r_mm  <= r_mm + 1'b1;
              end else begin
                r_pix <= r_pix + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            // Leave only once the last write is on the outputs, so out_we never
            // appears outside RUN/DRAIN and done follows the final write directly.
            if (!(r_v0 || r_v1 || r_v2)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            if (!en) begin
              r_state <= S_IDLE;
              r_done  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign acc_ra  = r_acc_ra;
  assign bias_ra = r_bias_ra;
  assign out_we  = r_out_we;
  assign out_wa  = r_out_wa;
  assign out_wd  = r_out_wd;
  assign done    = r_done;

endmodule

// File: tb/tb_bias_relu.sv
module tb_bias_relu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] R = '0, C = '0, M = '0;
  logic [15:0] acc_ra, bias_ra, out_wa, out_wd;
  logic [15:0] acc_rd = '0, bias_rd = '0;
  logic        out_we, done;

  logic [15:0] acc_mem  [0:65535];
  logic [15:0] bias_mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_n     = 0;
  int a1_cyc   = -1;
  int done_cyc = -1;
  logic [15:0] wr_addr [0:63];
  logic [15:0] wr_data [0:63];
  int          wr_cyc  [0:63];
  logic [15:0] exp_d   [0:63];

  bias_relu #(.DATA_SIZE(16), .MEM_SIZE(16)) dut (
    .clk(clk), .rst(rst), .en(en), .R(R), .C(C), .M(M),
    .acc_ra(acc_ra), .acc_rd(acc_rd), .bias_ra(bias_ra), .bias_rd(bias_rd),
    .out_we(out_we), .out_wa(out_wa), .out_wd(out_wd), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffers with one cycle of latency.
  always @(posedge clk) begin
    cyc = cyc + 1;
    acc_rd  <= acc_mem[acc_ra];
    bias_rd <= bias_mem[bias_ra];
  end

  // Write log and event timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = out_wa;
        wr_data[wr_n] = out_wd;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (a1_cyc < 0 && acc_ra == 16'd1) a1_cyc = cyc;
    if (done_cyc < 0 && done) done_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_n     = 0;
    a1_cyc   = -1;
    done_cyc = -1;
  endtask

  task automatic start_layer(input logic [15:0] r, input logic [15:0] c, input logic [15:0] m);
    en = 1'b0;
    @(negedge clk);
    R = r; C = c; M = m;
    clear_log();
    en = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int n);
    check_eq({tag, "_count"}, wr_n, n);
    for (int i = 0; i < n && i < wr_n && i < 64; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), {16'd0, wr_addr[i]}, i);
      check_eq($sformatf("%s_data%0d", tag, i), {16'd0, wr_data[i]}, {16'd0, exp_d[i]});
    end
  endtask

  task automatic load_basic();
    acc_mem[0] = 16'd5;  acc_mem[1] = -16'sd3; acc_mem[2] = 16'd0;  acc_mem[3] = 16'd7;
    acc_mem[4] = -16'sd1; acc_mem[5] = 16'd2;  acc_mem[6] = -16'sd8; acc_mem[7] = 16'd4;
    bias_mem[0] = 16'd1; bias_mem[1] = -16'sd2;
    exp_d[0] = 16'd6; exp_d[1] = 16'd0; exp_d[2] = 16'd1; exp_d[3] = 16'd8;
    exp_d[4] = 16'd0; exp_d[5] = 16'd0; exp_d[6] = 16'd0; exp_d[7] = 16'd2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int drop_cyc;
    int late;
    for (int i = 0; i < 65536; i++) begin
      acc_mem[i]  = '0;
      bias_mem[i] = '0;
    end

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_we",  {31'd0, out_we}, 32'd0);
    check_eq("rst_done",    {31'd0, done},   32'd0);
    check_eq("rst_acc_ra",  {16'd0, acc_ra},  32'd0);
    check_eq("rst_bias_ra", {16'd0, bias_ra}, 32'd0);
    check_eq("rst_out_wa",  {16'd0, out_wa},  32'd0);
    check_eq("rst_out_wd",  {16'd0, out_wd},  32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic stream: 2 maps of 2x2
    load_basic();
    start_layer(16'd2, 16'd2, 16'd2);
    wait_done("basic", 100);
    check_writes("basic", 8);
    check_eq("basic_latency",   wr_cyc[0], a1_cyc + 2);
    check_eq("basic_burst",     wr_cyc[7] - wr_cyc[0], 32'd7);
    check_eq("basic_done_rise", done_cyc, wr_cyc[7] + 1);
    repeat (3) @(negedge clk);
    check_eq("basic_done_hold", {31'd0, done}, 32'd1);

    // Overflow handling: positive and negative overflow
    acc_mem[0] = 16'h7FF0; bias_mem[0] = 16'h0020;
    acc_mem[1] = 16'h8000; bias_mem[1] = 16'hFFFF;
`ifdef BIAS_RELU_SAT_EN
    exp_d[0] = 16'h7FFF; exp_d[1] = 16'h0000;
`else
    exp_d[0] = 16'h0000; exp_d[1] = 16'h7FFF;
`endif
    start_layer(16'd1, 16'd1, 16'd2);
    wait_done("sat", 50);
    check_writes("sat", 2);

    // Zero dimension goes straight to DONE without writes
    start_layer(16'd2, 16'd2, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("zero_done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("zero_no_writes", wr_n, 32'd0);
    en = 1'b0;
    @(negedge clk);
    check_eq("zero_done_drop", {31'd0, done}, 32'd0);

    // Abort mid-run, then full restart
    for (int i = 0; i < 16; i++) acc_mem[i] = 16'(3 * i - 20);
    bias_mem[0] = 16'd5;
    start_layer(16'd4, 16'd4, 16'd1);
    repeat (5) @(negedge clk);
    en = 1'b0;
    drop_cyc = cyc;
    repeat (12) @(negedge clk);
    late = 0;
    for (int i = 0; i < wr_n && i < 64; i++)
      if (wr_cyc[i] > drop_cyc) late++;
    check_eq("abort_inflight", {31'd0, late <= 2}, 32'd1);
    check_eq("abort_no_done",  {31'd0, done_cyc < 0}, 32'd1);
    check_eq("abort_partial",  {31'd0, wr_n < 16}, 32'd1);
    for (int i = 0; i < 16; i++) exp_d[i] = (3 * i - 15 > 0) ? 16'(3 * i - 15) : 16'd0;
    start_layer(16'd4, 16'd4, 16'd1);
    wait_done("restart", 100);
    check_writes("restart", 16);

    // Reset during DRAIN, en held high: restarts from address 0
    load_basic();
    start_layer(16'd2, 16'd2, 16'd2);
    for (int k = 0; k < 50 && acc_ra != 16'd7; k++) @(negedge clk);
    check_eq("rst_mid_reach", {16'd0, acc_ra}, 32'd7);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_out_we", {31'd0, out_we}, 32'd0);
    check_eq("rst_mid_done",   {31'd0, done},   32'd0);
    check_eq("rst_mid_acc_ra", {16'd0, acc_ra}, 32'd0);
    rst = 1'b1;
    clear_log();
    wait_done("rst_restart", 100);
    check_writes("rst_restart", 8);

    // Back-to-back layer with a one-cycle en gap
    acc_mem[0] = 16'd10; acc_mem[1] = 16'd20; acc_mem[2] = 16'd30;
    acc_mem[3] = 16'd40; acc_mem[4] = 16'd50; acc_mem[5] = 16'd60;
    bias_mem[0] = 16'd1; bias_mem[1] = 16'd100;
    exp_d[0] = 16'd11;  exp_d[1] = 16'd21;  exp_d[2] = 16'd31;
    exp_d[3] = 16'd140; exp_d[4] = 16'd150; exp_d[5] = 16'd160;
    start_layer(16'd1, 16'd3, 16'd2);
    wait_done("b2b", 100);
    check_writes("b2b", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
